// File: rtl/cache_store_buffer_l1.sv
// In-order store buffer between the core and the L1 store aligner; drains one entry per cycle.
// Latency: a store accepted at edge N is presented on drain_* from cycle N+1. Backpressure: st_ready_o drops when full or flushing.
module cache_store_buffer_l1 #(
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [ADDR_WIDTH-1:0] st_addr_i,
    input  logic [63:0]           st_data_i,
    input  logic [2:0]            st_funct3_i,
    output logic                  misalign_o,
    output logic                  drain_valid_o,
    input  logic                  drain_ready_i,
    output logic [ADDR_WIDTH-1:0] drain_addr_o,
    output logic [63:0]           drain_data_o,
    output logic [2:0]            drain_funct3_o,
    output logic [1:0]            drain_word_o,
    output logic [1:0]            drain_offset_o,
    input  logic                  ld_check_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    output logic                  ld_conflict_o,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [PTR_W:0]        count_o,
    output logic                  empty_o
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [PTR_W:0]        DEPTH_C   = (PTR_W+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(7);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [63:0]           data_q [DEPTH];
    logic [2:0]            f3_q   [DEPTH];
    logic [DEPTH-1:0]      vld_q;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count_q;
    state_t           state_q, state_d;
    logic             done_d, flush_done_q, misalign_q;
    logic             accept, legal, push, pop;

    assign st_ready_o = (count_q < DEPTH_C) && (state_q == RUN);
    assign accept     = st_valid_i && st_ready_o;

    always_comb begin
        legal = 1'b1;
        case (st_funct3_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = (st_addr_i[0] == 1'b0);
            3'b010:  legal = (st_addr_i[1:0] == 2'b00);
            3'b011:  legal = (st_addr_i[2:0] == 3'b000);
            default: legal = 1'b0;
        endcase
    end

    assign push          = accept && legal;
    assign empty_o       = (count_q == '0);
    assign drain_valid_o = !empty_o;
    assign pop           = drain_valid_o && drain_ready_i;
    assign count_o       = count_q;
    assign misalign_o    = misalign_q;
    assign flush_done_o  = flush_done_q;

    assign drain_addr_o   = addr_q[rd_ptr];
    assign drain_data_o   = data_q[rd_ptr];
    assign drain_funct3_o = f3_q[rd_ptr];
    assign drain_word_o   = addr_q[rd_ptr][3:2];
    assign drain_offset_o = addr_q[rd_ptr][1:0];

    // Doubleword-granular compare; a same-cycle push is not yet in vld_q.
    always_comb begin
        ld_conflict_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (((addr_q[i] ^ ld_addr_i) & LINE_MASK) == '0))
                ld_conflict_o = ld_check_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                f3_q[i]   <= '0;
            end
            vld_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= st_addr_i;
                data_q[wr_ptr] <= st_data_i;
                f3_q[wr_ptr]   <= st_funct3_i;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_i) state_d = FLUSH;
            end
            FLUSH: begin
                if (count_q == '0) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            flush_done_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= done_d;
            misalign_q   <= accept && !legal;
        end
    end

endmodule

// File: tb/tb_cache_store_buffer_l1.sv
// Self-checking bench: store table plus hand sequences, drains checked against a scoreboard queue.
module tb_cache_store_buffer_l1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        st_valid_i, st_ready_o;
    logic [31:0] st_addr_i;
    logic [63:0] st_data_i;
    logic [2:0]  st_funct3_i;
    logic        misalign_o, drain_valid_o, drain_ready_i;
    logic [31:0] drain_addr_o;
    logic [63:0] drain_data_o;
    logic [2:0]  drain_funct3_o;
    logic [1:0]  drain_word_o, drain_offset_o;
    logic        ld_check_i, ld_conflict_o, flush_i, flush_done_o, empty_o;
    logic [31:0] ld_addr_i;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [2:0]  f3;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [2:0]  f3;
        logic        exp_mis;
        logic [1:0]  exp_word;
        logic [1:0]  exp_off;
    } vec_t;

    cache_store_buffer_l1 dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
        .st_data_i(st_data_i), .st_funct3_i(st_funct3_i), .misalign_o(misalign_o),
        .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
        .drain_addr_o(drain_addr_o), .drain_data_o(drain_data_o),
        .drain_funct3_o(drain_funct3_o), .drain_word_o(drain_word_o),
        .drain_offset_o(drain_offset_o), .ld_check_i(ld_check_i), .ld_addr_i(ld_addr_i),
        .ld_conflict_o(ld_conflict_o), .flush_i(flush_i), .flush_done_o(flush_done_o),
        .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [31:0] a, input logic [2:0] f);
        case (f)
            3'b000:  return 1'b1;
            3'b001:  return a[0] == 1'b0;
            3'b010:  return a[1:0] == 2'b00;
            3'b011:  return a[2:0] == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_store(input logic v, input logic [31:0] a, input logic [63:0] d, input logic [2:0] f);
        st_valid_i  = v;
        st_addr_i   = a;
        st_data_i   = d;
        st_funct3_i = f;
    endtask

    // Scoreboard: pops are checked before this edge's accept is recorded.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb.delete();
        end else begin
            if (drain_valid_o && drain_ready_i) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_drain", {32'h0, drain_addr_o}, 64'hFFFF_FFFF);
                end else begin
                    chk("sb_addr", {32'h0, drain_addr_o}, {32'h0, sb[0].addr});
                    chk("sb_data", drain_data_o, sb[0].data);
                    chk("sb_funct3", {61'h0, drain_funct3_o}, {61'h0, sb[0].f3});
                    void'(sb.pop_front());
                end
            end
            if (st_valid_i && st_ready_o && is_legal(st_addr_i, st_funct3_i))
                sb.push_back('{st_addr_i, st_data_i, st_funct3_i});
        end
    end

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h0000_1008, 64'h0000_0000_DEAD_BEEF, 3'b010, 1'b0, 2'b10, 2'b00};
        vecs[1]  = '{32'h0000_0021, 64'h0000_0000_0000_1234, 3'b001, 1'b1, 2'b00, 2'b00};
        vecs[2]  = '{32'h0000_0022, 64'h0000_0000_5555_6666, 3'b010, 1'b1, 2'b00, 2'b00};
        vecs[3]  = '{32'h0000_0013, 64'h0000_0000_0000_00C3, 3'b000, 1'b0, 2'b00, 2'b11};
        vecs[4]  = '{32'h0000_0016, 64'h0000_0000_0000_BEEF, 3'b001, 1'b0, 2'b01, 2'b10};
        vecs[5]  = '{32'h0000_0100, 64'h0123_4567_89AB_CDEF, 3'b011, 1'b0, 2'b00, 2'b00};
        vecs[6]  = '{32'h0000_0104, 64'hFFFF_0000_FFFF_0000, 3'b011, 1'b1, 2'b00, 2'b00};
        vecs[7]  = '{32'h0000_0040, 64'h0000_0000_0000_0042, 3'b100, 1'b1, 2'b00, 2'b00};
        vecs[8]  = '{32'h0000_100C, 64'h0000_0000_CAFE_F00D, 3'b010, 1'b0, 2'b11, 2'b00};
        vecs[9]  = '{32'h0000_0002, 64'h0000_0000_0000_A5A5, 3'b001, 1'b0, 2'b00, 2'b10};
        vecs[10] = '{32'h0000_0007, 64'h0000_0000_0000_0077, 3'b000, 1'b0, 2'b01, 2'b11};
        vecs[11] = '{32'h0000_0008, 64'h0000_0000_0000_0088, 3'b111, 1'b1, 2'b00, 2'b00};

        rst_ni = 1'b0;
        set_store(1'b0, 32'h0, 64'h0, 3'b000);
        drain_ready_i = 1'b0;
        ld_check_i    = 1'b0;
        ld_addr_i     = 32'h0;
        flush_i       = 1'b0;

        // Reset values, during and after reset
        #2;
        chk("rst_ready", {63'h0, st_ready_o}, 64'h1);
        chk("rst_drain_valid", {63'h0, drain_valid_o}, 64'h0);
        chk("rst_count", {61'h0, count_o}, 64'h0);
        chk("rst_empty", {63'h0, empty_o}, 64'h1);
        chk("rst_misalign", {63'h0, misalign_o}, 64'h0);
        chk("rst_drain_data", drain_data_o, 64'h0);
        chk("rst_drain_addr", {32'h0, drain_addr_o}, 64'h0);
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", {63'h0, st_ready_o}, 64'h1);
        chk("post_rst_empty", {63'h0, empty_o}, 64'h1);
        chk("post_rst_flush_done", {63'h0, flush_done_o}, 64'h0);
        tick();

        // Table: one store per vector with the drain side always ready
        drain_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_store(1'b1, vecs[i].addr, vecs[i].data, vecs[i].f3);
            @(negedge clk_i);
            chk("tbl_ready", {63'h0, st_ready_o}, 64'h1);
            tick();
            set_store(1'b0, 32'h0, 64'h0, 3'b000);
            @(negedge clk_i);
            chk("tbl_misalign", {63'h0, misalign_o}, {63'h0, vecs[i].exp_mis});
            chk("tbl_drain_valid", {63'h0, drain_valid_o}, {63'h0, !vecs[i].exp_mis});
            chk("tbl_count", {61'h0, count_o}, {63'h0, !vecs[i].exp_mis});
            if (!vecs[i].exp_mis) begin
                chk("tbl_word", {62'h0, drain_word_o}, {62'h0, vecs[i].exp_word});
                chk("tbl_offset", {62'h0, drain_offset_o}, {62'h0, vecs[i].exp_off});
            end
            tick();
            @(negedge clk_i);
            chk("tbl_empty_after", {63'h0, empty_o}, 64'h1);
            chk("tbl_misalign_pulse", {63'h0, misalign_o}, 64'h0);
            tick();
        end

        // Fill to full with drain blocked; fifth store must wait
        drain_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, 32'h10 + 32'(i), 64'hA1 + 64'(i), 3'b000);
            tick();
        end
        set_store(1'b1, 32'h14, 64'hA5, 3'b000);
        @(negedge clk_i);
        chk("full_count", {61'h0, count_o}, 64'd4);
        chk("full_ready", {63'h0, st_ready_o}, 64'h0);
        tick();
        set_store(1'b0, 32'h0, 64'h0, 3'b000);
        @(negedge clk_i);
        chk("full_no_fifth", {61'h0, count_o}, 64'd4);
        tick();
        drain_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("full_drain_valid", {63'h0, drain_valid_o}, 64'h1);
            chk("full_drain_offset", {62'h0, drain_offset_o}, 64'(i));
            chk("full_drain_data", drain_data_o, 64'hA1 + 64'(i));
            tick();
        end
        @(negedge clk_i);
        chk("full_empty", {63'h0, empty_o}, 64'h1);
        tick();

        // Load conflict against a pending SD
        drain_ready_i = 1'b0;
        set_store(1'b1, 32'h200, 64'h2222, 3'b011);
        ld_check_i = 1'b1;
        ld_addr_i  = 32'h200;
        #1;
        chk("ld_same_cycle_push", {63'h0, ld_conflict_o}, 64'h0);
        tick();
        set_store(1'b0, 32'h0, 64'h0, 3'b000);
        drain_ready_i = 1'b1;
        tick();
        drain_ready_i = 1'b0;
        set_store(1'b1, 32'h100, 64'h1111_2222_3333_4444, 3'b011);
        ld_check_i = 1'b0;
        tick();
        set_store(1'b0, 32'h0, 64'h0, 3'b000);
        ld_check_i = 1'b1;
        ld_addr_i  = 32'h104;
        #1;
        chk("ld_hit_104", {63'h0, ld_conflict_o}, 64'h1);
        ld_addr_i = 32'h108;
        #1;
        chk("ld_miss_108", {63'h0, ld_conflict_o}, 64'h0);
        ld_check_i = 1'b0;
        ld_addr_i  = 32'h104;
        #1;
        chk("ld_no_check", {63'h0, ld_conflict_o}, 64'h0);
        ld_check_i    = 1'b1;
        drain_ready_i = 1'b1;
        #1;
        chk("ld_hit_while_popping", {63'h0, ld_conflict_o}, 64'h1);
        tick();
        drain_ready_i = 1'b0;
        #1;
        chk("ld_after_drain", {63'h0, ld_conflict_o}, 64'h0);
        ld_check_i = 1'b0;
        tick();

        // Flush with two queued entries
        set_store(1'b1, 32'h300, 64'h3000, 3'b010);
        tick();
        set_store(1'b1, 32'h304, 64'h3004, 3'b010);
        tick();
        set_store(1'b0, 32'h0, 64'h0, 3'b000);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        set_store(1'b1, 32'h308, 64'h3008, 3'b010);
        @(negedge clk_i);
        chk("flush_ready_low", {63'h0, st_ready_o}, 64'h0);
        chk("flush_count", {61'h0, count_o}, 64'd2);
        tick();
        set_store(1'b0, 32'h0, 64'h0, 3'b000);
        drain_ready_i = 1'b1;
        tick();
        tick();
        @(negedge clk_i);
        chk("flush_drained", {63'h0, empty_o}, 64'h1);
        chk("flush_done_early", {63'h0, flush_done_o}, 64'h0);
        chk("flush_still_blocked", {63'h0, st_ready_o}, 64'h0);
        tick();
        @(negedge clk_i);
        chk("flush_done_pulse", {63'h0, flush_done_o}, 64'h1);
        chk("flush_ready_back", {63'h0, st_ready_o}, 64'h1);
        tick();
        @(negedge clk_i);
        chk("flush_done_one_cycle", {63'h0, flush_done_o}, 64'h0);
        tick();

        // Flush while empty: one FLUSH cycle, then done
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("eflush_ready_low", {63'h0, st_ready_o}, 64'h0);
        tick();
        @(negedge clk_i);
        chk("eflush_done", {63'h0, flush_done_o}, 64'h1);
        tick();

        // Reset in the middle of a flush discards everything
        drain_ready_i = 1'b0;
        set_store(1'b1, 32'h400, 64'h4000, 3'b011);
        tick();
        set_store(1'b0, 32'h0, 64'h0, 3'b000);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        rst_ni  = 1'b0;
        #1;
        chk("mrst_empty", {63'h0, empty_o}, 64'h1);
        chk("mrst_ready", {63'h0, st_ready_o}, 64'h1);
        chk("mrst_drain_valid", {63'h0, drain_valid_o}, 64'h0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("mrst_no_done", {63'h0, flush_done_o}, 64'h0);
            chk("mrst_run_ready", {63'h0, st_ready_o}, 64'h1);
            tick();
        end

        chk("sb_leftover", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
